// File: rtl/uart_tx_sequencer.sv
// ---------------------------------------------------------------------------
// uart_tx_sequencer
//   Frame controller for the UART transmit pin. It accepts one word per start
//   handshake and sends it as a frame: one start bit, DATA_BITS data bits
//   (LSB first), one stop bit, no parity. Every bit lasts CLKS_PER_BIT
//   cycles. It also drives the select input of the pin mux:
//   mux_sel = 0 picks a constant 1 (idle and stop), and mux_sel = 1 picks
//   the serial bit (start and data).
//
// Ports
//   clk       in   system clock; all state changes on the rising edge
//   rst       in   asynchronous reset, active high
//   tx_start  in   send request; looked at only while idle
//   tx_data   in   word to send; captured on the edge that accepts it
//   tx_busy   out  high while a frame is in flight
//   tx_done   out  one-cycle pulse in the last cycle of the stop bit
//   mux_sel   out  pin mux select (0 = constant 1, 1 = serial bit)
//   tx        out  serial line
//
// All outputs come from flops so the pin never glitches. Each flop loads
// the value decoded from the next state. As a result the outputs line up
// with state_q and do not lag it by a cycle.
// ---------------------------------------------------------------------------
module uart_tx_sequencer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 mux_sel,
  output logic                 tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e                state_q,    state_d;
  logic [CW-1:0]         baud_cnt_q, baud_cnt_d;
  logic [IW-1:0]         bit_idx_q,  bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q,    shift_d;
  logic                  tx_q,       tx_d;
  logic                  mux_sel_q,  mux_sel_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;

  logic bit_end;
  assign bit_end = (baud_cnt_q == BAUD_LAST);

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      mux_sel_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      mux_sel_q  <= mux_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic, then output decode from the next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    mux_sel_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (tx_start) begin
          shift_d   = tx_data;
          bit_idx_d = '0;
          state_d   = S_START;
        end
      end

      S_START: begin
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        if (bit_end) state_d = S_DATA;
      end

      S_DATA: begin
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        if (bit_end) begin
          // The shift after the last bit is harmless because STOP ignores it.
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) state_d = S_STOP;
        end
      end

      S_STOP: begin
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The output flops load the values for the cycle that state_d describes.
    // The line therefore falls in the first cycle after the accepting edge.
    case (state_d)
      S_START: begin
        tx_d      = 1'b0;
        mux_sel_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_DATA: begin
        tx_d      = shift_d[0];
        mux_sel_d = 1'b1;
        busy_d    = 1'b1;
      end
      S_STOP: begin
        busy_d = 1'b1;
        // Entering STOP always loads baud_cnt_d = 0, and CLKS_PER_BIT >= 2,
        // so this is true only in the last stop cycle.
        done_d = (baud_cnt_d == BAUD_LAST);
      end
      default: ;
    endcase
  end

  assign tx      = tx_q;
  assign mux_sel = mux_sel_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
